// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes, grant codes, phase states and light decode for phase_scheduler
// Contents: L_* light codes, G_* grant/owner codes, state_t, lights_t, decode()
package traffic_pkg;
   localparam logic [1:0] L_OFF = 2'd0;
   localparam logic [1:0] L_GRN = 2'd1;
   localparam logic [1:0] L_YEL = 2'd2;
   localparam logic [1:0] L_RED = 2'd3;
   localparam logic [1:0] G_MAIN = 2'd0;
   localparam logic [1:0] G_SIDE = 2'd1;
   localparam logic [1:0] G_WALK = 2'd2;
   localparam logic [1:0] G_NONE = 2'd3;
   typedef enum logic [2:0] {MAIN_G, MAIN_Y, ALL_R, SIDE_G, SIDE_Y, WALK} state_t;
   typedef struct packed {
      logic [1:0] main_light;
      logic [1:0] side_light;
      logic       walk_light;
      logic [1:0] grant;
   } lights_t;
   function automatic lights_t decode(state_t s);
      return s == MAIN_G ? lights_t'{L_GRN, L_RED, 1'b0, G_MAIN} :
             s == MAIN_Y ? lights_t'{L_YEL, L_RED, 1'b0, G_NONE} :
             s == ALL_R  ? lights_t'{L_RED, L_RED, 1'b0, G_NONE} :
             s == SIDE_G ? lights_t'{L_RED, L_GRN, 1'b0, G_SIDE} :
             s == SIDE_Y ? lights_t'{L_RED, L_YEL, 1'b0, G_NONE} :
             s == WALK   ? lights_t'{L_RED, L_RED, 1'b1, G_WALK} :
                           lights_t'{L_OFF, L_OFF, 1'b0, G_NONE};
   endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: 4-bit tick-driven phase countdown, loadable, freezable, saturating at 0
// Ports: clk, reset (async active-low), load, load_val[3:0], tick, freeze -> count[3:0], done
module phase_timer #(
   parameter logic [3:0] RST_VAL = 4'd0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       tick,
   input  logic       freeze,
   output logic [3:0] count,
   output logic       done
);
   assign done = tick && count == 4'd0;
   always_ff @(posedge clk or negedge reset)
      if (!reset) count <= RST_VAL;
      else if (load) count <= load_val;
      else if (tick && !freeze && count != 4'd0) count <= count - 4'd1;
endmodule

// File: rtl/phase_scheduler.sv
// phase_scheduler: arbitrates the crossing between main road, side road and pedestrians
// Ports: clk, reset (async active-low), tick (1 Hz strobe), sensor, walk [, emrg]
//        -> main_light[1:0], side_light[1:0], walk_light, grant[1:0], remaining[3:0]
// Option: PHASE_SCHEDULER_EMRG_EN adds input emrg that forces traffic back to main green
module phase_scheduler import traffic_pkg::*; #(
   parameter int TMIN_MAIN = 6,
   parameter int TSIDE     = 4,
   parameter int TWALK     = 5,
   parameter int TYEL      = 2,
   parameter int TCLR      = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       sensor,
   input  logic       walk,
`ifdef PHASE_SCHEDULER_EMRG_EN
   input  logic       emrg,
`endif
   output logic [1:0] main_light,
   output logic [1:0] side_light,
   output logic       walk_light,
   output logic [1:0] grant,
   output logic [3:0] remaining
);
`ifndef PHASE_SCHEDULER_EMRG_EN
   logic emrg;
   assign emrg = 1'b0;
`endif
   state_t     state, nxt;
   logic [1:0] next_owner, nxt_owner, last_served;
   logic       side_req, walk_req, side_any, walk_any, done, load, freeze, enter_side, enter_walk;
   logic [3:0] load_val, count;
   assign side_any   = side_req | sensor;
   assign walk_any   = walk_req | walk;
   assign load       = nxt != state;
   assign enter_side = load && nxt == SIDE_G;
   assign enter_walk = load && nxt == WALK;
   assign freeze     = emrg && state == MAIN_G;
   assign remaining  = count;
   assign load_val = nxt == MAIN_G ? 4'(TMIN_MAIN - 1) :
                     nxt == SIDE_G ? 4'(TSIDE - 1) :
                     nxt == WALK   ? 4'(TWALK - 1) :
                     nxt == ALL_R  ? 4'(TCLR - 1) : 4'(TYEL - 1);
   always_comb begin
      nxt = state;
      nxt_owner = next_owner;
      case (state)
         MAIN_G: nxt = done && !emrg && (side_any || walk_any) ? MAIN_Y : MAIN_G;
         MAIN_Y: if (done) begin
            nxt = ALL_R;
            nxt_owner = side_req && walk_req ? (last_served == G_WALK ? G_SIDE : G_WALK) :
                        side_req ? G_SIDE : walk_req ? G_WALK : G_MAIN;
         end
         ALL_R: if (done) nxt = emrg || next_owner == G_MAIN ? MAIN_G :
                                next_owner == G_SIDE ? SIDE_G : WALK;
         SIDE_G: nxt = done || emrg ? SIDE_Y : SIDE_G;
         SIDE_Y: if (done) begin
            nxt = ALL_R;
            nxt_owner = G_MAIN;
         end
         WALK: if (done || emrg) begin
            nxt = ALL_R;
            nxt_owner = G_MAIN;
         end
         default: nxt = ALL_R;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= ALL_R;
         next_owner <= G_MAIN;
         last_served <= G_WALK;
         side_req <= 1'b0;
         walk_req <= 1'b0;
         {main_light, side_light, walk_light, grant} <= decode(ALL_R);
      end else begin
         state <= nxt;
         next_owner <= nxt_owner;
         last_served <= enter_side ? G_SIDE : enter_walk ? G_WALK : last_served;
         side_req <= side_any && !enter_side;
         walk_req <= walk_any && !enter_walk;
         {main_light, side_light, walk_light, grant} <= decode(nxt);
      end
   phase_timer #(.RST_VAL(4'(TCLR - 1))) u_timer (
      .clk(clk),
      .reset(reset),
      .load(load),
      .load_val(load_val),
      .tick(tick),
      .freeze(freeze),
      .count(count),
      .done(done)
   );
endmodule

// File: tb/tb_phase_scheduler.sv
// tb_phase_scheduler: table-driven and directed checks of phase_scheduler sequencing
module tb_phase_scheduler;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tick = 1'b0;
   logic       sensor = 1'b0;
   logic       walk = 1'b0;
`ifdef PHASE_SCHEDULER_EMRG_EN
   logic       emrg = 1'b0;
`endif
   logic [1:0] main_light, side_light, grant;
   logic       walk_light;
   logic [3:0] remaining;
   int n_checks = 0;
   int n_fail = 0;
   typedef struct {
      bit         rst;
      int         n;
      bit         s;
      bit         w;
      logic [1:0] ml;
      logic [1:0] sl;
      logic       wl;
      logic [1:0] g;
      logic [3:0] rem;
   } vec_t;
   vec_t vecs[$];
   always #5 clk = ~clk;
   phase_scheduler dut (
      .clk(clk),
      .reset(reset),
      .tick(tick),
      .sensor(sensor),
      .walk(walk),
`ifdef PHASE_SCHEDULER_EMRG_EN
      .emrg(emrg),
`endif
      .main_light(main_light),
      .side_light(side_light),
      .walk_light(walk_light),
      .grant(grant),
      .remaining(remaining)
   );
   task automatic check(input string name, input logic [1:0] ml, input logic [1:0] sl,
                        input logic wl, input logic [1:0] g, input logic [3:0] rem);
      n_checks++;
      if ({main_light, side_light, walk_light, grant, remaining} !== {ml, sl, wl, g, rem}) begin
         n_fail++;
         $display("FAIL %s: got ml=%0d sl=%0d wl=%0d g=%0d rem=%0d, expected ml=%0d sl=%0d wl=%0d g=%0d rem=%0d",
                  name, main_light, side_light, walk_light, grant, remaining, ml, sl, wl, g, rem);
      end
   endtask
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      tick = 1'b0;
      sensor = 1'b0;
      walk = 1'b0;
`ifdef PHASE_SCHEDULER_EMRG_EN
      emrg = 1'b0;
`endif
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask
   task automatic tick_once(input bit s, input bit w);
      @(negedge clk);
      tick = 1'b1;
      sensor = s;
      walk = w;
      @(negedge clk);
      tick = 1'b0;
      sensor = 1'b0;
      walk = 1'b0;
      @(negedge clk);
   endtask
   initial begin
      // side request during main green, full side cycle back to main
      vecs.push_back('{1, 1, 0, 0, 2'd1, 2'd3, 1'b0, 2'd0, 4'd5});
      vecs.push_back('{0, 1, 1, 0, 2'd1, 2'd3, 1'b0, 2'd0, 4'd4});
      vecs.push_back('{0, 4, 0, 0, 2'd1, 2'd3, 1'b0, 2'd0, 4'd0});
      vecs.push_back('{0, 1, 0, 0, 2'd2, 2'd3, 1'b0, 2'd3, 4'd1});
      vecs.push_back('{0, 1, 0, 0, 2'd2, 2'd3, 1'b0, 2'd3, 4'd0});
      vecs.push_back('{0, 1, 0, 0, 2'd3, 2'd3, 1'b0, 2'd3, 4'd0});
      vecs.push_back('{0, 1, 0, 0, 2'd3, 2'd1, 1'b0, 2'd1, 4'd3});
      vecs.push_back('{0, 3, 0, 0, 2'd3, 2'd1, 1'b0, 2'd1, 4'd0});
      vecs.push_back('{0, 1, 0, 0, 2'd3, 2'd2, 1'b0, 2'd3, 4'd1});
      vecs.push_back('{0, 1, 0, 0, 2'd3, 2'd2, 1'b0, 2'd3, 4'd0});
      vecs.push_back('{0, 1, 0, 0, 2'd3, 2'd3, 1'b0, 2'd3, 4'd0});
      vecs.push_back('{0, 1, 0, 0, 2'd1, 2'd3, 1'b0, 2'd0, 4'd5});
      // both pending: side first, re-request both, walk next, then side
      vecs.push_back('{1, 1, 1, 1, 2'd1, 2'd3, 1'b0, 2'd0, 4'd5});
      vecs.push_back('{0, 5, 0, 0, 2'd1, 2'd3, 1'b0, 2'd0, 4'd0});
      vecs.push_back('{0, 1, 0, 0, 2'd2, 2'd3, 1'b0, 2'd3, 4'd1});
      vecs.push_back('{0, 2, 0, 0, 2'd3, 2'd3, 1'b0, 2'd3, 4'd0});
      vecs.push_back('{0, 1, 0, 0, 2'd3, 2'd1, 1'b0, 2'd1, 4'd3});
      vecs.push_back('{0, 1, 1, 1, 2'd3, 2'd1, 1'b0, 2'd1, 4'd2});
      vecs.push_back('{0, 3, 0, 0, 2'd3, 2'd2, 1'b0, 2'd3, 4'd1});
      vecs.push_back('{0, 2, 0, 0, 2'd3, 2'd3, 1'b0, 2'd3, 4'd0});
      vecs.push_back('{0, 1, 0, 0, 2'd1, 2'd3, 1'b0, 2'd0, 4'd5});
      vecs.push_back('{0, 6, 0, 0, 2'd2, 2'd3, 1'b0, 2'd3, 4'd1});
      vecs.push_back('{0, 2, 0, 0, 2'd3, 2'd3, 1'b0, 2'd3, 4'd0});
      vecs.push_back('{0, 1, 0, 0, 2'd3, 2'd3, 1'b1, 2'd2, 4'd4});
      vecs.push_back('{0, 4, 0, 0, 2'd3, 2'd3, 1'b1, 2'd2, 4'd0});
      vecs.push_back('{0, 1, 0, 0, 2'd3, 2'd3, 1'b0, 2'd3, 4'd0});
      vecs.push_back('{0, 1, 0, 0, 2'd1, 2'd3, 1'b0, 2'd0, 4'd5});
      vecs.push_back('{0, 6, 0, 0, 2'd2, 2'd3, 1'b0, 2'd3, 4'd1});
      vecs.push_back('{0, 2, 0, 0, 2'd3, 2'd3, 1'b0, 2'd3, 4'd0});
      vecs.push_back('{0, 1, 0, 0, 2'd3, 2'd1, 1'b0, 2'd1, 4'd3});
      // walk arrives on the resting main-green phase-end tick
      vecs.push_back('{1, 1, 0, 0, 2'd1, 2'd3, 1'b0, 2'd0, 4'd5});
      vecs.push_back('{0, 10, 0, 0, 2'd1, 2'd3, 1'b0, 2'd0, 4'd0});
      vecs.push_back('{0, 1, 0, 1, 2'd2, 2'd3, 1'b0, 2'd3, 4'd1});
      vecs.push_back('{0, 2, 0, 0, 2'd3, 2'd3, 1'b0, 2'd3, 4'd0});
      vecs.push_back('{0, 1, 0, 0, 2'd3, 2'd3, 1'b1, 2'd2, 4'd4});
      do_reset();
      check("reset", 2'd3, 2'd3, 1'b0, 2'd3, 4'd0);
      for (int k = 1; k <= 20; k++) begin
         tick_once(0, 0);
         check($sformatf("idle_tick%0d", k), 2'd1, 2'd3, 1'b0, 2'd0, k < 6 ? 4'(6 - k) : 4'd0);
      end
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) do_reset();
         tick_once(vecs[i].s, vecs[i].w);
         repeat (vecs[i].n - 1) tick_once(0, 0);
         check($sformatf("vec%0d", i), vecs[i].ml, vecs[i].sl, vecs[i].wl, vecs[i].g, vecs[i].rem);
      end
      do_reset();
      tick_once(1, 0);
      repeat (9) tick_once(0, 0);
      check("pre_async_side_g", 2'd3, 2'd1, 1'b0, 2'd1, 4'd3);
      tick_once(1, 1);
      #2 reset = 1'b0;
      #1 check("async_reset", 2'd3, 2'd3, 1'b0, 2'd3, 4'd0);
      @(negedge clk);
      reset = 1'b1;
      tick_once(0, 0);
      repeat (6) tick_once(0, 0);
      check("reqs_discarded", 2'd1, 2'd3, 1'b0, 2'd0, 4'd0);
`ifdef PHASE_SCHEDULER_EMRG_EN
      do_reset();
      tick_once(0, 1);
      repeat (6) tick_once(0, 0);
      check("emrg_main_y", 2'd2, 2'd3, 1'b0, 2'd3, 4'd1);
      repeat (3) tick_once(0, 0);
      check("emrg_walk_entry", 2'd3, 2'd3, 1'b1, 2'd2, 4'd4);
      tick_once(1, 0);
      emrg = 1'b1;
      @(negedge clk);
      check("emrg_forced_all_r", 2'd3, 2'd3, 1'b0, 2'd3, 4'd0);
      tick_once(0, 0);
      check("emrg_main_g", 2'd1, 2'd3, 1'b0, 2'd0, 4'd5);
      repeat (3) tick_once(0, 0);
      check("emrg_frozen", 2'd1, 2'd3, 1'b0, 2'd0, 4'd5);
      emrg = 1'b0;
      repeat (5) tick_once(0, 0);
      check("emrg_min_green", 2'd1, 2'd3, 1'b0, 2'd0, 4'd0);
      tick_once(0, 0);
      check("emrg_after_y", 2'd2, 2'd3, 1'b0, 2'd3, 4'd1);
      repeat (3) tick_once(0, 0);
      check("emrg_side_served", 2'd3, 2'd1, 1'b0, 2'd1, 4'd3);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/phase_scheduler.md
Name: phase_scheduler

Overview:
- Sequences the intersection's shared crossing resource between three requesters: main road (default owner), side road (sensor) and pedestrians (walk button).
- Latches requests and enforces minimum main-green time, yellow and all-red clearance.
- Round-robins between pending side and walk requests and drives the light codes consumed by the seven-segment display driver.
- Sits between the 1 Hz tick from clockDivider and the display/multiplex logic.

Parameters:
- TMIN_MAIN, 6: minimum main green, in ticks (1..15).
- TSIDE, 4: side green duration, in ticks (1..15).
- TWALK, 5: walk phase duration, in ticks (1..15).
- TYEL, 2: yellow duration, in ticks (1..15).
- TCLR, 1: all-red clearance, in ticks (1..15).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-low reset.
- tick  input  1  one-clk-wide timing strobe (1 Hz).
- sensor  input  1  side-road vehicle present (level, synchronous to clk).
- walk  input  1  pedestrian button (level or pulse, synchronous to clk).
- main_light  output  2  light code: 0 off, 1 green, 2 yellow, 3 red.
- side_light  output  2  light code, same encoding.
- walk_light  output  1  pedestrian walk lamp.
- grant  output  2  current owner: 0 main, 1 side, 2 walk, 3 none (clearance or yellow).
- remaining  output  4  ticks left in the current phase, for display.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset=0 resets immediately, independent of clk).
- States:
  - MAIN_G: lights G/r, grant=0.
  - MAIN_Y: lights Y/r, grant=3.
  - ALL_R: lights R/r, grant=3.
  - SIDE_G: lights R/g, grant=1.
  - SIDE_Y: lights R/y, grant=3.
  - WALK: lights R/r, walk_light=1, grant=2.
- Reset values:
  - state=ALL_R, next_owner=main, timer=TCLR-1, last_served=walk.
  - Both requests cleared.
  - main_light=3, side_light=3, walk_light=0, grant=3, remaining=TCLR-1.
- Timer:
  - 4-bit; loaded with duration-1 on state entry.
  - Decrements only on cycles with tick=1.
  - The phase ends on a cycle where tick=1 and timer=0, so each phase lasts exactly N ticks.
  - No wrap-around: the timer never decrements below 0.
- Transitions (all taken on a phase-end cycle):
  - MAIN_G: exit to MAIN_Y only if side_req or walk_req is pending; otherwise hold the timer at 0 and rest in MAIN_G indefinitely.
  - MAIN_Y -> ALL_R: next_owner is chosen at this transition.
    - Only one request pending: that request.
    - Both pending: the one opposite to last_served.
  - ALL_R -> SIDE_G, WALK or MAIN_G, per next_owner.
  - SIDE_G -> SIDE_Y -> ALL_R (next_owner=main).
  - WALK -> ALL_R (next_owner=main).
  - last_served updates on entry to SIDE_G or WALK.
- Request latching:
  - side_req is set on any cycle with sensor=1; walk_req is set on any cycle with walk=1.
  - Each request is cleared on its grant-entry cycle; clear wins if set and clear coincide.
  - Assertions after the entry cycle re-latch a new request.
- Outputs:
  - All outputs are registered.
  - They update on the same edge as the state change (one clk after the phase-end cycle).
  - remaining = timer.
- Simultaneous events:
  - tick plus a new request on the MAIN_G phase-end cycle: the request is honoured in that same cycle.
  - Reset mid-phase: returns to the reset state immediately; all latched requests are discarded.

Optional Feature:
- Macro: PHASE_SCHEDULER_EMRG_EN.
- With the macro:
  - Adds input emrg (1 bit).
  - While emrg=1, SIDE_G is forced to SIDE_Y and WALK is forced to ALL_R on the next clk, ignoring the timer.
  - After those forced exits, ALL_R routes to MAIN_G.
  - MAIN_G is then held with the timer frozen.
  - Pending requests are retained and served normally after emrg falls.
- Without the macro: no emrg port; behaviour is exactly as described above.

Decomposition:
- Package traffic_pkg holds:
  - Light code constants: L_OFF=0, L_GRN=1, L_YEL=2, L_RED=3.
  - Grant codes.
  - The state enum {MAIN_G, MAIN_Y, ALL_R, SIDE_G, SIDE_Y, WALK}.
- Sub-module phase_timer:
  - Ports: clk, reset, load, load_val[3:0], tick, freeze.
  - Outputs: count[3:0], done = (tick && count==0).

Test Plan:
- Release reset with no requests, then 20 ticks: ALL_R for 1 tick, then MAIN_G held; remaining sits at 0; grant=0 throughout.
- sensor pulse at tick 2 of MAIN_G: MAIN_G ends at tick 6, then MAIN_Y 2 ticks, ALL_R 1, SIDE_G 4 (side_light=1, grant=1), SIDE_Y 2, ALL_R 1, then back to MAIN_G.
- sensor and walk both pending, last_served=walk: side is served first. Re-request both during the side phase: the next cycle serves WALK for 5 ticks with walk_light=1.
- walk pulse aligned with the MAIN_G phase-end tick: the MAIN_Y transition occurs on that cycle.
- reset=0 asserted mid-SIDE_G without any clk edge: outputs read 3/3/0/3 immediately; requests are cleared.
- PHASE_SCHEDULER_EMRG_EN build, emrg=1 at tick 1 of WALK: next clk enters ALL_R, then MAIN_G with the timer frozen while emrg is held. A side request latched before emrg is served after emrg falls and min green expires.
